// File: rtl/l2_tile_sequencer_if.sv
// Sequencer-to-datapath bundle: pass control in, BRAM/ROM addressing and strobes out.
// Pure wiring; no storage or latency of its own.
// The sequencer side drives everything except start/stall, which come from the controller.
interface l2_tile_sequencer_if #(
   parameter int ADDR_W = 10
) ();
   logic              start;
   logic              stall;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] bram_addr;
   logic [2:0]        lane_sel;
   logic [3:0]        w2_addr;
   logic [2:0]        w3_addr;
   logic              sel_conv3;
   logic              padding;
   logic              acc_clear;
   logic              load;
   logic [ADDR_W-1:0] out_addr;
   logic              skip_we;
   logic [ADDR_W-1:0] skip_addr;

   // Sequencer side.
   modport master (
      input  start, stall,
      output busy, done, bram_addr, lane_sel, w2_addr, w3_addr, sel_conv3,
             padding, acc_clear, load, out_addr, skip_we, skip_addr
   );

   // Controller / datapath side.
   modport slave (
      output start, stall,
      input  busy, done, bram_addr, lane_sel, w2_addr, w3_addr, sel_conv3,
             padding, acc_clear, load, out_addr, skip_we, skip_addr
   );
endinterface

// File: rtl/l2_tile_sequencer.sv
// Layer-2 tile sequencer: walks every output pixel through 16 conv2 steps, 8 conv3 steps and a load.
// Latency: first conv2 step is visible the cycle after start is taken; 25 cycles/pixel, done one cycle after the last load.
// Backpressure: stall freezes state/counters/addresses and suppresses load, skip_we, acc_clear and done for that cycle.
module l2_tile_sequencer #(
   parameter int IMG_W  = 16,
   parameter int IMG_H  = 16,
   parameter int ADDR_W = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   l2_tile_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CONV2 = 3'd1,
      S_CONV3 = 3'd2,
      S_LOAD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] HALF_W = ADDR_W'(IMG_W / 2);
   localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] LAST_Y = ADDR_W'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
   localparam logic [3:0]        K2_END = 4'd15;
   localparam logic [3:0]        K3_END = 4'd7;

   state_t            state_q, state_d;
   logic [3:0]        k_q, k_d;
   logic [ADDR_W-1:0] x_q, x_d;
   logic [ADDR_W-1:0] y_q, y_d;

   // Address arithmetic is a pure function of the registered pixel position,
   // so neither start nor stall can reach any address output.
   logic [ADDR_W-1:0] pix_addr;
   logic [ADDR_W-1:0] above_addr;
   logic [ADDR_W-1:0] skip_pix;

   assign pix_addr   = (y_q * W_A) + x_q;
   // Only consumed when y>0, so the subtraction never underflows.
   assign above_addr = pix_addr - W_A;
   // Skip buffer is half-width: two horizontally adjacent pixels share a slot.
   assign skip_pix   = (y_q * HALF_W) + (x_q >> 1);

   // State, step counter and pixel position registers; reset returns to an idle, zeroed sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // Next-state: start is only honoured in IDLE without stall; any other stalled cycle holds everything.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      x_d     = x_q;
      y_d     = y_q;
      if (state_q == S_IDLE) begin
         if (bus.start && !bus.stall) begin
            state_d = S_CONV2;
            k_d     = '0;
            x_d     = '0;
            y_d     = '0;
         end
      end else if (!bus.stall) begin
         case (state_q)
            S_CONV2: begin
               if (k_q == K2_END) begin
                  state_d = S_CONV3;
                  k_d     = '0;
               end else begin
                  k_d = k_q + 4'd1;
               end
            end
            S_CONV3: begin
               if (k_q == K3_END) begin
                  state_d = S_LOAD;
                  k_d     = '0;
               end else begin
                  k_d = k_q + 4'd1;
               end
            end
            S_LOAD: begin
               k_d = '0;
               if (x_q == LAST_X) begin
                  x_d = '0;
                  if (y_q == LAST_Y) begin
                     // Last pixel written: park position at zero and signal completion.
                     y_d     = '0;
                     state_d = S_DONE;
                  end else begin
                     y_d     = y_q + ONE_A;
                     state_d = S_CONV2;
                  end
               end else begin
                  x_d     = x_q + ONE_A;
                  state_d = S_CONV2;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Output decode from registered state; only the four strobes see stall, and only to suppress them.
   always_comb begin
      bus.busy      = (state_q != S_IDLE);
      bus.done      = 1'b0;
      bus.bram_addr = '0;
      bus.lane_sel  = 3'd0;
      bus.w2_addr   = 4'd0;
      bus.w3_addr   = 3'd0;
      bus.sel_conv3 = 1'b0;
      bus.padding   = 1'b0;
      bus.acc_clear = 1'b0;
      bus.load      = 1'b0;
      bus.out_addr  = '0;
      bus.skip_we   = 1'b0;
      bus.skip_addr = '0;
      case (state_q)
         S_CONV2: begin
            bus.w2_addr  = k_q;
            bus.lane_sel = k_q[2:0];
            if (!k_q[3]) begin
               // First half reads the row above; on the top row that row is the zero border.
               if (y_q == '0) begin
                  bus.padding   = 1'b1;
                  bus.bram_addr = '0;
               end else begin
                  bus.bram_addr = above_addr;
               end
            end else begin
               bus.bram_addr = pix_addr;
            end
            bus.acc_clear = (k_q == 4'd0) && !bus.stall;
         end
         S_CONV3: begin
            bus.w3_addr   = k_q[2:0];
            bus.lane_sel  = k_q[2:0];
            bus.sel_conv3 = 1'b1;
            bus.bram_addr = pix_addr;
         end
         S_LOAD: begin
            bus.load      = !bus.stall;
            bus.out_addr  = pix_addr;
            bus.skip_addr = skip_pix;
            // Only even columns land in the half-width skip buffer.
            bus.skip_we   = !bus.stall && !x_q[0];
         end
         S_DONE: begin
            bus.done = !bus.stall;
         end
         default: begin
            bus.busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_l2_tile_sequencer.sv
// Bench for l2_tile_sequencer on a 4x4 map: full passes with stalls, ignored starts and a mid-pass reset.
// Timing is tracked as "position" = un-stalled cycle index after the start edge (1 = conv2 k=0 of pixel 0).
// Outputs are sampled 1 ns after the falling edge, after inputs for that cycle are driven.
module tb_l2_tile_sequencer;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst;

   l2_tile_sequencer_if #(.ADDR_W(AW)) bus ();

   l2_tile_sequencer #(
      .IMG_W  (4),
      .IMG_H  (4),
      .ADDR_W (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pos;
      bit ld_row;
      int bram;
      bit pad;
      int lane;
      bit sel3;
      bit acc;
      int w;
      int oaddr;
      bit swe;
      int saddr;
   } vec_t;

   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] all_out();
      return 64'({bus.busy, bus.done, bus.bram_addr, bus.lane_sel, bus.w2_addr, bus.w3_addr,
                  bus.sel_conv3, bus.padding, bus.acc_clear, bus.load, bus.out_addr,
                  bus.skip_we, bus.skip_addr});
   endfunction

   function automatic void add_c(int pos, int bram, bit pad, int lane, bit sel3, bit acc, int w);
      vec_t v;
      v = '{default: 0};
      v.pos = pos; v.bram = bram; v.pad = pad; v.lane = lane;
      v.sel3 = sel3; v.acc = acc; v.w = w;
      tbl.push_back(v);
   endfunction

   function automatic void add_l(int pos, int oaddr, bit swe, int saddr);
      vec_t v;
      v = '{default: 0};
      v.pos = pos; v.ld_row = 1'b1; v.oaddr = oaddr; v.swe = swe; v.saddr = saddr;
      tbl.push_back(v);
   endfunction

   // Hand-computed per-position vectors; strobes are expected suppressed when stalled.
   task automatic check_rows(input int pos, input bit stl);
      foreach (tbl[i]) begin
         if (tbl[i].pos == pos) begin
            if (tbl[i].ld_row) begin
               chk($sformatf("p%0d load", pos),      bus.load,      !stl);
               chk($sformatf("p%0d out_addr", pos),  bus.out_addr,  tbl[i].oaddr);
               chk($sformatf("p%0d skip_we", pos),   bus.skip_we,   tbl[i].swe & !stl);
               chk($sformatf("p%0d skip_addr", pos), bus.skip_addr, tbl[i].saddr);
            end else begin
               chk($sformatf("p%0d bram_addr", pos), bus.bram_addr, tbl[i].bram);
               chk($sformatf("p%0d padding", pos),   bus.padding,   tbl[i].pad);
               chk($sformatf("p%0d lane_sel", pos),  bus.lane_sel,  tbl[i].lane);
               chk($sformatf("p%0d sel_conv3", pos), bus.sel_conv3, tbl[i].sel3);
               chk($sformatf("p%0d acc_clear", pos), bus.acc_clear, tbl[i].acc & !stl);
               chk($sformatf("p%0d w_addr", pos),
                   tbl[i].sel3 ? 64'(bus.w3_addr) : 64'(bus.w2_addr), tbl[i].w);
            end
         end
      end
   endtask

   // Every-cycle expectations from the 25-cycle pixel schedule.
   task automatic check_cycle(input int pos, input bit stl);
      int pix, ph, p;
      bit exp_ld;
      pix    = (pos - 1) / 25;
      ph     = (pos - 1) % 25;
      p      = pos / 25 - 1;
      exp_ld = (pos >= 25) && (pos <= 400) && (pos % 25 == 0) && !stl;
      chk($sformatf("c%0d busy", pos),      bus.busy,      pos <= 401);
      chk($sformatf("c%0d done", pos),      bus.done,      (pos == 401) && !stl);
      chk($sformatf("c%0d load", pos),      bus.load,      exp_ld);
      chk($sformatf("c%0d acc_clear", pos), bus.acc_clear, (pos <= 400) && (ph == 0) && !stl);
      chk($sformatf("c%0d padding", pos),   bus.padding,   (pos <= 400) && (pix < 4) && (ph < 8));
      chk($sformatf("c%0d skip_we", pos),   bus.skip_we,   exp_ld && (p % 2 == 0));
      if (exp_ld) begin
         chk($sformatf("c%0d out_addr", pos),  bus.out_addr,  p);
         chk($sformatf("c%0d skip_addr", pos), bus.skip_addr, (p / 4) * 2 + (p % 4) / 2);
      end
   endtask

   task automatic do_abort();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      #1;
      chk("abort outputs immediate", all_out(), 64'd0);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         chk("abort outputs held", all_out(), 64'd0);
      end
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         chk("post-abort busy", bus.busy, 1'b0);
         chk("post-abort done", bus.done, 1'b0);
         chk("post-abort load", bus.load, 1'b0);
      end
   endtask

   // One pass: stall windows [sa,sa+la) and [sb,sb+lb) in observation index, optional stray starts,
   // optional reset at a given position.
   task automatic run_pass(input string nm, input int sa, input int la, input int sb, input int lb,
                           input int rs_obs, input bit start_in_done, input int abort_pos,
                           output int done_obs, output int loads);
      int obs, pos;
      bit fin, stl;
      done_obs  = -1;
      loads     = 0;
      bus.stall = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      obs = 1;
      pos = 1;
      fin = 1'b0;
      while (!fin && obs <= 450) begin
         stl       = ((obs >= sa) && (obs < sa + la)) || ((obs >= sb) && (obs < sb + lb));
         bus.stall = stl;
         bus.start = (obs == rs_obs) || (start_in_done && pos == 401);
         #1;
         check_cycle(pos, stl);
         check_rows(pos, stl);
         if (bus.done) done_obs = obs;
         if (bus.load) loads++;
         if (pos == abort_pos) begin
            do_abort();
            fin = 1'b1;
         end else if (pos == 402) begin
            fin = 1'b1;
         end else begin
            @(posedge clk);
            if (!stl) pos++;
            @(negedge clk);
            obs++;
         end
      end
      bus.start = 1'b0;
      bus.stall = 1'b0;
      if (!fin) begin
         total++;
         bad++;
         $display("FAIL %s timeout: pass not finished, pos=%0d want 402", nm, pos);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d_obs, n_ld;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.stall = 1'b0;

      // conv rows: pos, bram, pad, lane, sel3, acc, w ; load rows: pos, out_addr, skip_we, skip_addr
      add_c(  1, 0, 1, 0, 0, 1,  0);
      add_l( 25, 0, 1, 0);
      add_c( 49, 1, 0, 7, 1, 0,  7);
      add_l( 50, 1, 0, 0);
      add_c( 51, 0, 1, 0, 0, 1,  0);
      add_c( 58, 0, 1, 7, 0, 0,  7);
      add_c( 59, 2, 0, 0, 0, 0,  8);
      add_c( 66, 2, 0, 7, 0, 0, 15);
      add_c( 67, 2, 0, 0, 1, 0,  0);
      add_c( 74, 2, 0, 7, 1, 0,  7);
      add_l( 75, 2, 1, 1);
      add_c(126, 1, 0, 0, 0, 1,  0);
      add_c(134, 5, 0, 0, 0, 0,  8);
      add_c(226, 5, 0, 0, 0, 1,  0);
      add_c(233, 5, 0, 7, 0, 0,  7);
      add_c(234, 9, 0, 0, 0, 0,  8);
      add_c(241, 9, 0, 7, 0, 0, 15);
      add_c(245, 9, 0, 3, 1, 0,  3);
      add_l(250, 9, 0, 4);
      add_l(375, 14, 1, 7);
      add_l(400, 15, 0, 7);

      // Reset state, including with start/stall wiggling under reset.
      #2;
      chk("reset outputs", all_out(), 64'd0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.stall = 1'b1;
      #1;
      chk("reset outputs with inputs", all_out(), 64'd0);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.stall = 1'b0;
      rst       = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("idle after reset", all_out(), 64'd0);

      // IDLE: start together with stall is ignored; stall alone does nothing.
      bus.start = 1'b1;
      bus.stall = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      chk("idle start+stall busy", bus.busy, 1'b0);
      chk("idle stall outputs", all_out(), 64'd0);
      @(posedge clk);
      @(negedge clk);
      bus.stall = 1'b0;
      #1;
      chk("idle after stall", all_out(), 64'd0);

      run_pass("basic", 0, 0, 0, 0, 0, 1'b0, 0, d_obs, n_ld);
      chk("basic done cycle", d_obs, 401);
      chk("basic load count", n_ld, 16);

      run_pass("stall", 49, 3, 0, 0, 50, 1'b0, 0, d_obs, n_ld);
      chk("stall done cycle", d_obs, 404);
      chk("stall load count", n_ld, 16);

      run_pass("restart", 101, 1, 402, 1, 5, 1'b1, 0, d_obs, n_ld);
      chk("restart done cycle", d_obs, 403);
      chk("restart load count", n_ld, 16);

      run_pass("abort", 0, 0, 0, 0, 0, 1'b0, 128, d_obs, n_ld);
      chk("abort no done", d_obs >= 0, 1'b0);
      chk("abort load count", n_ld, 5);

      run_pass("after abort", 0, 0, 0, 0, 0, 1'b0, 0, d_obs, n_ld);
      chk("after abort done cycle", d_obs, 401);
      chk("after abort load count", n_ld, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/l2_tile_sequencer.md
L2_TILE_SEQUENCER -- requirements
Module: l2_tile_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- IMG_W, 16, output columns per feature map.
- IMG_H, 16, output rows per feature map.
- ADDR_W, 10, width of all BRAM address outputs; IMG_W*IMG_H SHALL be at most 2^ADDR_W.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, begin one full-layer pass; sampled only in IDLE.
- stall, in, 1, freeze the sequencer for this cycle.
- busy, out, 1, high from the first step through the DONE cycle.
- done, out, 1, one-cycle pulse at the end of a pass.
- bram_addr, out, ADDR_W, input-feature BRAM word address.
- lane_sel, out, 3, selects one 128-bit slice of the 1024-bit BRAM word.
- w2_addr, out, 4, conv2 weight ROM address.
- w3_addr, out, 3, conv3 weight ROM address.
- sel_conv3, out, 1, high selects conv3 weights and bias.
- padding, out, 1, datapath substitutes zero for BRAM data.
- acc_clear, out, 1, clear the adder-tree accumulator.
- load, out, 1, the accumulated result is valid and is to be written.
- out_addr, out, ADDR_W, output BRAM address, equal to y*IMG_W+x.
- skip_we, out, 1, skip-buffer write enable.
- skip_addr, out, ADDR_W, skip-buffer address, equal to y*(IMG_W/2)+x/2.

Function
REQ-003 States SHALL be IDLE, CONV2, CONV3, LOAD and DONE.
REQ-004 Transitions SHALL be as follows.
- IDLE goes to CONV2 on start.
- CONV2 goes to CONV3 after step 15.
- CONV3 goes to LOAD after step 7.
- LOAD goes to CONV2 for the next pixel, or to DONE after the last pixel.
- DONE goes to IDLE unconditionally.
REQ-005 Pixel order SHALL be raster: x runs from 0 to IMG_W-1 fastest, then y runs from 0 to IMG_H-1.
REQ-006 CONV2 SHALL run a 4-bit step counter k from 0 to 15, with these outputs at each step:
- w2_addr = k.
- lane_sel = k[2:0].
- sel_conv3 = 0.
- bram_addr = (y-1+k[3])*IMG_W + x.
REQ-007 In CONV2, when y==0 and k<8, padding SHALL be 1 and bram_addr SHALL be 0; padding SHALL be 0 in every other case.
REQ-008 CONV3 SHALL run k from 0 to 7, with these outputs at each step:
- w3_addr = k.
- lane_sel = k.
- sel_conv3 = 1.
- padding = 0.
- bram_addr = y*IMG_W + x.
REQ-009 acc_clear SHALL be 1 only in the CONV2 k=0 cycle of each pixel.
REQ-010 In LOAD, load SHALL be 1, and out_addr and skip_addr SHALL hold the current pixel's addresses.
REQ-011 skip_we SHALL equal load AND (x[0]==0).
REQ-012 Each pixel SHALL take 25 un-stalled cycles (16 + 8 + 1).
REQ-013 A pass SHALL take 25*IMG_W*IMG_H un-stalled cycles, and done SHALL assert in the following cycle.
REQ-014 If start is sampled high in IDLE at edge T0, the CONV2 k=0 outputs SHALL be visible during the cycle after T0.
REQ-015 While stall=1, all of the following SHALL hold:
- state, counters and address outputs hold their values;
- load, skip_we, acc_clear and done are forced to 0;
- no step is consumed;
- the held step re-issues with its strobes when stall drops.
REQ-016 start SHALL be ignored in every state except IDLE, including DONE and any stalled cycle.
REQ-017 stall in IDLE SHALL have no effect, and start with stall=1 in IDLE SHALL be ignored.
REQ-018 Address arithmetic SHALL be computed at ADDR_W bits with no wrap; for legal parameters, bram_addr SHALL never exceed IMG_W*IMG_H-1.
REQ-019 All outputs SHALL be driven from registered state, with no combinational path from start or stall to any address output.

Reset
REQ-020 Asserting rst SHALL immediately force the state machine to IDLE and clear all counters, x and y.
REQ-021 While rst is asserted, every output SHALL be 0.
REQ-022 Asserting rst mid-pass SHALL abort the pass with no done pulse, and no load or skip_we SHALL occur after rst rises.
REQ-023 After rst falls, the block SHALL wait in IDLE for a new start.

Verification
REQ-024 Bench parameters SHALL be IMG_W=4 and IMG_H=4, and the bench SHALL cover the following scenarios.
- Basic pass: start at edge T0 with no stall -> load high at T0+25*(p+1) for p=0..15; out_addr = p; done only at T0+401; busy low at T0+402.
- Padding: pixel x=2, y=0 -> padding=1 and bram_addr=0 for CONV2 k=0..7; bram_addr=2 for k=8..15; bram_addr=2 through CONV3.
- Interior and skip: pixel x=1, y=2 -> CONV2 k=0..7 bram_addr=5; k=8..15 bram_addr=9; CONV3 bram_addr=9. At pixel x=2, y=3 -> skip_we=1 with skip_addr=7. At x=1 -> skip_we=0.
- Stall: stall held high 3 cycles at CONV3 k=7 -> outputs frozen; load appears exactly 3 cycles later than un-stalled timing; done at T0+404.
- Restart: start pulsed during CONV2 and in the DONE cycle -> no effect; start in the cycle after DONE begins a new pass.
- Reset mid-pass: rst asserted at CONV2 of pixel 5 -> all outputs 0 immediately; no done pulse; a new start after release yields the same timing as the basic pass.
